regfile_bypass_sb: RTL
======================

// Module: regfile_bypass_sb
// PURPOSE
//  Parametrised integer register file for the pipelined RV32I core: 2 combinational read ports,
//  1 write port with optional write-through bypass, and a per-register busy scoreboard for hazards.
//  After reset, a sweep FSM clears one register per cycle, so the array maps to LUTRAM/BRAM
//  (no whole-array reset). Sits between decode (reads, issue) and writeback (write, busy clear).
// PARAMETERS
//  XLEN    32  data width in bits
//  NREG    32  number of registers; power of 2, >=2; AW = $clog2(NREG)
//  BYPASS  1   1: same-cycle write data forwarded to read ports; 0: read returns old array value
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  reset      in   1        asynchronous, active-high
//  ready      out  1        1 = init sweep done, file usable
//  rs1_addr   in   AW       read port 1 address
//  rs2_addr   in   AW       read port 2 address
//  rd1_data   out  XLEN     read port 1 data (combinational)
//  rd2_data   out  XLEN     read port 2 data (combinational)
//  rd1_busy   out  1        scoreboard bit of rs1_addr (combinational)
//  rd2_busy   out  1        scoreboard bit of rs2_addr (combinational)
//  wr_en      in   1        writeback strobe
//  wr_addr    in   AW       writeback register
//  wr_data    in   XLEN     writeback data
//  iss_en     in   1        issue strobe: mark iss_addr busy (pending producer)
//  iss_addr   in   AW       destination register of issued instruction
// BEHAVIOUR
//  FSM: INIT -> RUN. Async reset forces INIT, idx=0, busy[]=0, ready=0.
//  INIT: each cycle writes regs[idx]=0, idx++; on idx==NREG-1 -> RUN next cycle.
//   ready rises exactly NREG cycles after reset deasserts; stays 1 until next reset.
//   In INIT: wr_en/iss_en ignored (dropped, not queued); rd*_data=0, rd*_busy=0.
//  Reset mid-operation (any state): returns to INIT at once, sweep restarts from idx 0.
//  RUN write: wr_en && wr_addr!=0 -> regs[wr_addr]<=wr_data at edge. Address 0 never written.
//  Reads: rdN_data = 0 if rsN_addr==0; else if BYPASS && wr_en && wr_addr==rsN_addr -> wr_data;
//   else regs[rsN_addr]. Both ports may alias the same address; identical results.
//  Scoreboard (RUN only), per register r at each edge:
//   set   = iss_en && iss_addr==r;  clr = wr_en && wr_addr==r
//   set wins over clr (same-cycle writeback of old producer + issue of new one -> stays busy).
//   busy[0] hard-wired 0; iss_en to r0 ignored.
//   wr_en to a non-busy register is legal: data written, busy unchanged (0).
//  rdN_busy = busy[rsN_addr] as registered state; no bypass of same-cycle set/clr.
//  Latency: write visible on read ports same cycle (BYPASS=1) or next cycle (BYPASS=0).
//  Reset values: ready=0, rd1/rd2_data=0, rd1/rd2_busy=0, all busy bits 0, array zero after sweep.
// TESTING
//  T1 reset pulse, hold ports idle -> ready=0 for 32 cycles, 1 on cycle 32; all 32 regs read 0.
//  T2 wr_en during INIT (x5<=0xDEAD) -> ignored; after ready, read x5=0.
//  T3 RUN: wr x7<=0x12345678, rs1=rs2=7 same cycle -> both 0x12345678 (BYPASS=1); BYPASS=0 old 0.
//  T4 write x0<=0xFFFFFFFF, iss x0 -> rd1_data=0, rd1_busy=0 on rs1=0.
//  T5 iss x3 -> rd1_busy(x3)=1 next cycle; wr x3 + iss x3 same cycle -> busy stays 1; wr x3 -> 0.
//  T6 reset mid-run with x9=0xA5A5A5A5, busy x9 -> ready=0, busy 0; after sweep x9 reads 0.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
// Integer register file with two combinational read ports, one write port with
// optional write-through bypass, a per-register busy scoreboard and a post-reset clear sweep.
module regfile_bypass_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            rd1_busy,
  output logic            rd2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] regs [NREG];

  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;

  logic            wr_live;
  logic            bypass1;
  logic            bypass2;

  // Sweep sequencer, ready flag and busy scoreboard; busy[0] only ever sees reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      idx   <= '0;
      ready <= 1'b0;
      busy  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          idx <= idx + AW'(1);
          if (idx == AW'(NREG - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          for (int r = 1; r < int'(NREG); r++) begin
            if (iss_en && (iss_addr == AW'(r))) begin
              busy[r] <= 1'b1;
            end else if (wr_en && (wr_addr == AW'(r))) begin
              busy[r] <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_INIT;
          idx   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Single array write port shared by the clear sweep and writeback.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = wr_addr;
    arr_wdata = wr_data;
    if (state == S_INIT) begin
      arr_we    = 1'b1;
      arr_waddr = idx;
      arr_wdata = '0;
    end else begin
      arr_we    = wr_en && (wr_addr != '0);
    end
  end

  // No reset on the array so it can map onto distributed or block RAM.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs[arr_waddr] <= arr_wdata;
    end
  end

  assign wr_live = BYPASS && (state == S_RUN) && wr_en;
  assign bypass1 = wr_live && (wr_addr == rs1_addr);
  assign bypass2 = wr_live && (wr_addr == rs2_addr);

  // Read ports: x0 and the sweep window read as zero, then bypass, then array.
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    rd1_busy = 1'b0;
    rd2_busy = 1'b0;
    if (state == S_RUN) begin
      if (rs1_addr != '0) begin
        rd1_data = bypass1 ? wr_data : regs[rs1_addr];
      end
      if (rs2_addr != '0) begin
        rd2_data = bypass2 ? wr_data : regs[rs2_addr];
      end
      rd1_busy = busy[rs1_addr];
      rd2_busy = busy[rs2_addr];
    end
  end

endmodule
